speed_meas_ctrl: RTL and testbench

//  Sequences the BLDC speed measurement path: synchronises the three hall inputs, counts hall-state

---
 rtl/bldc_speed_pkg.sv | 17 +
 rtl/hall_edge_det.sv | 33 +++
 rtl/speed_meas_ctrl.sv | 142 ++++++++++++++
 tb/tb_speed_meas_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bldc_speed_pkg.sv
// bldc_speed_pkg
//   Shared definitions for the BLDC speed measurement path: FSM state
//   encoding, default widths and the edge-count saturation value.
package bldc_speed_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GATE   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_LATCH  = 2'd3
   } state_t;

   localparam int CNT_W_DEF   = 8;
   localparam int RPM_W_DEF   = 10;
   localparam int CNT_MAX_DEF = 200;

endpackage

// File: rtl/hall_edge_det.sv
// hall_edge_det
//   Synchronises the three asynchronous hall inputs and flags every cycle in
//   which the synchronised vector differs from its value one cycle earlier.
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   hall   in   [2:0] raw hall inputs
//   chg    out  one-cycle pulse per synchronised hall-state change
module hall_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] hall,
   output logic       chg
);

   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic [2:0]                  prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], hall};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign chg = (sync_q[SYNC_STAGES-1] != prev_q);

endmodule

// File: rtl/speed_meas_ctrl.sv
// speed_meas_ctrl
//   Counts hall-state changes over a fixed gate window, snapshots the count
//   into the external count->rpm table and registers the table result.
//   Optional macro SPEED_AVG_EN: rpm is the truncated mean of the current and
//   previous table samples (first sample after IDLE is passed through).
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   en           measurement enable (level)
//   hall[2:0]    raw hall inputs
//   lut_addr     registered table address (count snapshot)
//   lut_data     table output, combinational from lut_addr
//   rpm          registered speed result
//   rpm_valid    one-cycle pulse when rpm/overrange update
//   overrange    last completed window saturated at CNT_MAX
//   busy         high whenever the FSM is not IDLE
module speed_meas_ctrl
   import bldc_speed_pkg::*;
#(
   parameter int GATE_CYCLES = 12_500_000,
   parameter int CNT_MAX     = CNT_MAX_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int RPM_W       = RPM_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       hall,
   output logic [CNT_W-1:0] lut_addr,
   input  logic [RPM_W-1:0] lut_data,
   output logic [RPM_W-1:0] rpm,
   output logic             rpm_valid,
   output logic             overrange,
   output logic             busy
);

   localparam int TMR_W = $clog2(GATE_CYCLES);

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  timer_q;
   logic [CNT_W-1:0]  cnt_q, cnt_inc;
   logic              ovr_next_q;
   logic              hall_chg;
   logic              win_end, snap, upd;
   logic [RPM_W-1:0]  rpm_nxt;

   hall_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .hall  (hall),
      .chg   (hall_chg)
   );

   assign win_end = (timer_q == TMR_W'(GATE_CYCLES - 1));
   // count including this cycle's change, held at CNT_MAX
   assign cnt_inc = (hall_chg && cnt_q != CNT_W'(CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
   assign snap    = en && (state_q == ST_GATE) && win_end;
   // lut_addr is stable for the whole SETTLE cycle, so the table output is
   // captured on the SETTLE->LATCH edge and rpm_valid is high during LATCH.
   assign upd     = en && (state_q == ST_SETTLE);
   assign busy    = (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en) state_d = ST_IDLE;
      else begin
         case (state_q)
            ST_IDLE:   state_d = ST_GATE;
            ST_GATE:   if (win_end) state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_GATE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Timer and counter run through SETTLE/LATCH: those cycles already belong
   // to the next window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q    <= '0;
         cnt_q      <= '0;
         lut_addr   <= '0;
         ovr_next_q <= 1'b0;
      end else if (!en || state_q == ST_IDLE) begin
         timer_q <= '0;
         cnt_q   <= '0;
      end else if (snap) begin
         timer_q    <= '0;
         cnt_q      <= '0;
         lut_addr   <= cnt_inc;
         ovr_next_q <= (cnt_inc == CNT_W'(CNT_MAX));
      end else begin
         timer_q <= win_end ? '0 : timer_q + TMR_W'(1);
         cnt_q   <= cnt_inc;
      end
   end

`ifdef SPEED_AVG_EN
   logic [RPM_W-1:0] prev_q;
   logic             have_prev_q;

   assign rpm_nxt = have_prev_q
                  ? RPM_W'(({1'b0, lut_data} + {1'b0, prev_q}) >> 1)
                  : lut_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         prev_q      <= '0;
         have_prev_q <= 1'b0;
      end else if (upd) begin
         prev_q      <= lut_data;
         have_prev_q <= 1'b1;
      end
   end
`else
   assign rpm_nxt = lut_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpm       <= '0;
         overrange <= 1'b0;
         rpm_valid <= 1'b0;
      end else begin
         rpm_valid <= upd;
         if (upd) begin
            rpm       <= rpm_nxt;
            overrange <= ovr_next_q;
         end
      end
   end

endmodule

// File: tb/tb_speed_meas_ctrl.sv
module tb_speed_meas_ctrl;
   localparam int G = 1000;

   logic       clk = 1'b0;
   logic       rst_n, en;
   logic [2:0] hall;
   logic [7:0] lut_addr;
   logic [9:0] lut_data, rpm;
   logic       rpm_valid, overrange, busy;

   always #5 clk = ~clk;

   // count->rpm table: 4 rpm per count
   assign lut_data = 10'(lut_addr) * 10'd4;

   speed_meas_ctrl #(.GATE_CYCLES(G), .CNT_MAX(200), .CNT_W(8), .RPM_W(10), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .hall(hall), .lut_addr(lut_addr),
      .lut_data(lut_data), .rpm(rpm), .rpm_valid(rpm_valid),
      .overrange(overrange), .busy(busy)
   );

   typedef struct {
      int addr;
      int rpm;
      int ovr;
      int at;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   pos    = 0;   // posedges since en was last raised

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (pos %0d)", name, act, exp, pos);
      end
   endtask

   task automatic push(input int addr, input int r, input int ovr, input int at);
      exp_t x;
      x.addr = addr; x.rpm = r; x.ovr = ovr; x.at = at;
      sb.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      pos++;
   endtask

   // Advance to end_pos, changing hall every other cycle n times from first.
   task automatic drive(input int end_pos, input int first, input int n);
      while (pos < end_pos) begin
         if (n > 0 && pos >= first && pos < first + 2*n && ((pos - first) % 2) == 0)
            hall = hall + 3'd1;
         tick();
      end
   endtask

   // Monitor: every rpm_valid pops one expectation, including when it arrives.
   always @(negedge clk) begin
      if (rst_n && rpm_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: rpm %0d at pos %0d, expected no update", rpm, pos);
         end else begin
            e = sb.pop_front();
            chk("rpm",         int'(rpm),       e.rpm);
            chk("overrange",   int'(overrange), e.ovr);
            chk("lut_addr",    int'(lut_addr),  e.addr);
            chk("valid_pos",   pos,             e.at);
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; hall = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rpm", int'(rpm), 0);
      chk("rst_valid", int'(rpm_valid), 0);
      chk("rst_addr", int'(lut_addr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ovr", int'(overrange), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      en = 1'b1; pos = 0;

      // 50 changes -> addr 50, rpm 200
      push(50, 200, 0, G + 2);
      drive(G, 10, 50);
      @(negedge clk);
      chk("busy_gate", int'(busy), 1);
      #4;
      // 250 changes saturate at 200
      push(200, 800, 1, 2*G + 2);
      drive(2*G, G + 10, 250);
      push(10, 40, 0, 3*G + 2);
      drive(3*G, 2*G + 10, 10);
      // quiet window except one change landing on the last window cycle
      push(1, 4, 0, 4*G + 2);
      drive(4*G - 1, 4*G - 2, 1);
      // change landing on the SETTLE cycle belongs to the next window
      push(1, 4, 0, 5*G + 2);
      drive(4*G, 4*G - 1, 1);
      drive(5*G, 0, 0);
      // zero edges
      push(0, 0, 0, 6*G + 2);
      drive(6*G, 0, 0);

      // 30 changes, then en dropped during SETTLE: no update
      drive(7*G + 1, 6*G + 10, 30);
      en = 1'b0;
      tick();
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_rpm", int'(rpm), 0);
      chk("abort_addr", int'(lut_addr), 30);
      chk("abort_valid", int'(rpm_valid), 0);
      #4;
      repeat (10) tick();

      // fresh start: 50 then 100 changes
      en = 1'b1; pos = 0;
      push(50, 200, 0, G + 2);
      drive(G, 10, 50);
`ifdef SPEED_AVG_EN
      push(100, 300, 0, 2*G + 2);
`else
      push(100, 400, 0, 2*G + 2);
`endif
      drive(2*G, G + 10, 100);
      drive(2*G + 5, 0, 0);
      en = 1'b0;
      repeat (3) tick();
      en = 1'b1; pos = 0;
      // first result after IDLE is unaveraged
      push(25, 100, 0, G + 2);
      drive(G, 10, 25);
      drive(G + 500, 0, 0);

      // asynchronous reset mid-GATE
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_rpm", int'(rpm), 0);
      chk("mid_rst_valid", int'(rpm_valid), 0);
      chk("mid_rst_addr", int'(lut_addr), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ovr", int'(overrange), 0);
      #2 rst_n = 1'b1;
      en = 1'b0;
      repeat (5) tick();
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
